// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one full_sub cell.
// Latency: WIDTH RUN cycles after acceptance, result held in DONE until consumed.
// Backpressure: start_ready only in IDLE; result held stable while res_ready=0.

module full_sub (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ c;
    assign bo = (~x & y) | (~(x ^ y) & c);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_b;
    logic [WIDTH:0]   dshift;

    full_sub u_cell (
        .x  (areg[0]),
        .y  (breg[0]),
        .c  (borrow),
        .d  (cell_d),
        .bo (cell_b)
    );

    // Extra bit lets the MSB insertion work for WIDTH=1 without an empty slice.
    assign dshift = {cell_d, diff};
    // The borrow flop doubles as the visible final borrow once RUN completes.
    assign bout   = borrow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            areg        <= '0;
            breg        <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
            diff        <= '0;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        areg        <= a;
                        breg        <= b;
                        borrow      <= bin;
                        cnt         <= '0;
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    borrow <= cell_b;
                    diff   <= dshift[WIDTH:1];
                    // Stop on the last bit rather than incrementing, so cnt never wraps.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: WIDTH=8 directed + random ops, WIDTH=1 truth table.
// Expected results come from plain integer subtraction of the accepted operands.

module tb_serial_sub_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sv8, sr8, rv8, rr8, bin8, bout8, busy8;
    logic [7:0] a8, b8, d8;
    logic       sv1, sr1, rv1, rr1, bin1, bout1, busy1;
    logic [0:0] a1, b1, d1;

    int passed = 0;
    int total  = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .bin(bin8), .res_valid(rv8), .res_ready(rr8),
        .diff(d8), .bout(bout8), .busy(busy8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .bin(bin1), .res_valid(rv1), .res_ready(rr1),
        .diff(d1), .bout(bout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge with dut8 idle; returns at the negedge after consumption.
    task automatic do_op8(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                          input int hold, input bit keep);
        int         d;
        logic [7:0] ed;
        logic       eb;
        int         runs;
        bit         seen;
        d  = int'(ai) - int'(bi) - int'(bini);
        ed = d[7:0];
        eb = (d < 0);
        check("idle_ready", 64'(sr8), 64'(1));
        a8 = ai; b8 = bi; bin8 = bini; sv8 = 1'b1;
        runs = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rv8) begin
                seen = 1;
            end else begin
                if (busy8) runs++;
                sv8  = keep;
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                bin8 = 1'($urandom);
                rr8  = 1'($urandom);
            end
        end
        check("completed", 64'(seen), 64'(1));
        check("run_cycles", 64'(runs), 64'(8));
        check("diff", 64'(d8), 64'(ed));
        check("bout", 64'(bout8), 64'(eb));
        check("done_busy", 64'(busy8), 64'(0));
        check("done_ready", 64'(sr8), 64'(0));
        for (int h = 0; h < hold; h++) begin
            rr8 = 1'b0;
            a8  = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 64'(rv8), 64'(1));
            check("hold_diff", 64'(d8), 64'(ed));
            check("hold_bout", 64'(bout8), 64'(eb));
            check("hold_ready", 64'(sr8), 64'(0));
        end
        rr8 = 1'b1;
        @(negedge clk);
        rr8 = 1'b0;
        sv8 = keep;
        check("post_ready", 64'(sr8), 64'(1));
        check("post_valid", 64'(rv8), 64'(0));
        check("post_diff", 64'(d8), 64'(ed));
    endtask

    initial begin
        rst_n = 1'b0;
        sv8 = 1'b1; rr8 = 1'b0; a8 = 8'h77; b8 = 8'h11; bin8 = 1'b1;
        sv1 = 1'b1; rr1 = 1'b0; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(sr8), 64'(1));
        check("rst_valid", 64'(rv8), 64'(0));
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_diff", 64'(d8), 64'(0));
        check("rst_bout", 64'(bout8), 64'(0));
        check("rst_w1_ready", 64'(sr1), 64'(1));
        check("rst_w1_busy", 64'(busy1), 64'(0));
        sv8 = 1'b0;
        sv1 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("no_accept_in_reset", 64'(busy8), 64'(0));

        do_op8(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
        do_op8(8'h00, 8'h01, 1'b0, 0, 1'b0);
        do_op8(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        do_op8(8'hC3, 8'h4D, 1'b1, 5, 1'b0);

        // Reset in the 4th RUN cycle, with a request presented during reset.
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; sv8 = 1'b1;
        @(negedge clk);
        sv8 = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", 64'(busy8), 64'(1));
        rst_n = 1'b0;
        sv8 = 1'b1;
        @(negedge clk);
        check("mr_ready", 64'(sr8), 64'(1));
        check("mr_valid", 64'(rv8), 64'(0));
        check("mr_busy", 64'(busy8), 64'(0));
        check("mr_diff", 64'(d8), 64'(0));
        check("mr_bout", 64'(bout8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sv8 = 1'b0;
        @(negedge clk);
        check("mr_no_accept", 64'(busy8), 64'(0));
        do_op8(8'h10, 8'h01, 1'b0, 0, 1'b0);

        // start_valid held high across several operations.
        for (int n = 0; n < 6; n++)
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
        for (int n = 0; n < 20; n++)
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        sv8 = 1'b0;

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            int         d;
            v = 3'(k);
            d = int'(v[2]) - int'(v[1]) - int'(v[0]);
            a1 = v[2]; b1 = v[1]; bin1 = v[0]; sv1 = 1'b1;
            @(negedge clk);
            sv1 = 1'b0;
            a1 = ~a1;
            check("w1_busy", 64'(busy1), 64'(1));
            check("w1_early", 64'(rv1), 64'(0));
            @(negedge clk);
            check("w1_valid", 64'(rv1), 64'(1));
            check("w1_diff", 64'(d1), 64'(d[0]));
            check("w1_bout", 64'(bout1), 64'(d < 0));
            rr1 = 1'b1;
            @(negedge clk);
            rr1 = 1'b0;
            check("w1_ready", 64'(sr1), 64'(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
